// File: rtl/mcx_pkg.sv
// Purpose: shared MCX constants: program store geometry, line field positions, loader states, register map.
// Latency: n/a (package only).
// Backpressure: n/a.
package mcx_pkg;

    localparam int ADDR_W     = 4;
    localparam int LINE_W     = 46;
    localparam int LINE_BYTES = (LINE_W + 7) / 8;   // derived: 6 bytes per line
    localparam int DEPTH      = 2 ** ADDR_W;
    localparam int SHIFT_W    = (LINE_BYTES - 1) * 8;  // bytes held before the closing byte

    // Instruction word field positions
    localparam int PC_HI   = 45;
    localparam int PC_LO   = 42;
    localparam int COND_HI = 41;
    localparam int COND_LO = 40;
    localparam int INST_HI = 39;
    localparam int INST_LO = 36;
    localparam int ARG1_HI = 35;
    localparam int ARG1_LO = 24;
    localparam int ARG2_HI = 23;
    localparam int ARG2_LO = 12;
    localparam int ARG3_HI = 11;
    localparam int ARG3_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } ld_state_e;

    // Register address map shared with the core
    localparam logic [11:0] REG_NULL = 12'h800;
    localparam logic [11:0] REG_ACC  = 12'h801;
    localparam logic [11:0] REG_DAT  = 12'h802;
    localparam logic [11:0] REG_P0   = 12'h803;
    localparam logic [11:0] REG_P1   = 12'h804;
    localparam logic [11:0] REG_X0   = 12'h805;
    localparam logic [11:0] REG_X1   = 12'h806;
    localparam logic [11:0] REG_X2   = 12'h807;
    localparam logic [11:0] REG_X3   = 12'h808;

endpackage

// File: rtl/prog_ram.sv
// Purpose: program store, 2**AW x DW registers with one write port and one combinational read port.
// Latency: read 0 cycles; a write is visible on the cycle after its write edge.
// Backpressure: none, accepts a write every cycle.
// Ports: clk, rst (async active-high, clears all lines), we/waddr/wdata write port, raddr/rdata read port.
module prog_ram #(
    parameter int AW = 4,
    parameter int DW = 46
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_loader.sv
// Purpose: fills the MCX program store from a byte stream and holds the core in reset until the load succeeds.
// Latency: a line is written on the edge accepting its 6th byte; core_nrst rises one cycle after entering DONE.
// Backpressure: rx_ready high only while expecting header/data/checksum bytes; rx_valid low stalls indefinitely.
// Ports: clk, rst (async active-high), start pulse, rx_data/rx_valid/rx_ready stream, addr->line fetch port,
//        core_nrst, busy, done, err status, lines_loaded count.
// Option: define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module prog_loader
    import mcx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] addr,
    output logic [LINE_W-1:0] line,
    output logic              core_nrst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   lines_loaded
);

    localparam logic [ADDR_W:0] ONE_L = 1;

    ld_state_e          state_q, state_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [2:0]         byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]    lines_q, lines_d;
    logic [ADDR_W:0]    n_q, n_d;
    logic               core_nrst_q, core_nrst_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic                     xfer;
    logic                     we;
    logic [SHIFT_W+7:0]       wr_word;
    logic [LINE_W-1:0]        wr_data;
    logic                     unused_pad;

    // Full 48-bit big-endian word; the two bits above LINE_W are padding and dropped.
    assign wr_word    = {shift_q, rx_data};
    assign wr_data    = wr_word[LINE_W-1:0];
    assign unused_pad = ^wr_word[SHIFT_W+7:LINE_W];

    assign rx_ready     = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign busy         = rx_ready;
    assign done         = (state_q == ST_DONE);
    assign err          = (state_q == ST_ERR);
    assign core_nrst    = core_nrst_q;
    assign lines_loaded = lines_q;
    assign xfer         = rx_valid && rx_ready;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        lines_d    = lines_q;
        n_d        = n_q;
        we         = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        // Release the core only while resting in DONE; a restart pulls it back into reset.
        core_nrst_d = (state_q == ST_DONE) && !start;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_HDR;
                    shift_d    = '0;
                    byte_cnt_d = '0;
                    lines_d    = '0;
                end
            end
            ST_HDR: begin
                if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d = rx_data;
`endif
                    if (rx_data == 8'd0 || rx_data > 8'(DEPTH)) begin
                        state_d = ST_ERR;
                    end else begin
                        n_d     = rx_data[ADDR_W:0];
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    if (byte_cnt_q == 3'(LINE_BYTES - 1)) begin
                        we         = 1'b1;
                        byte_cnt_d = '0;
                        lines_d    = lines_q + ONE_L;
                        if (lines_q + ONE_L == n_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state_d = ST_CSUM;
`else
                            state_d = ST_DONE;
`endif
                        end
                    end else begin
                        shift_d    = {shift_q[SHIFT_W-9:0], rx_data};
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (xfer) begin
                    state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            lines_q     <= '0;
            n_q         <= '0;
            core_nrst_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            byte_cnt_q  <= byte_cnt_d;
            lines_q     <= lines_d;
            n_q         <= n_d;
            core_nrst_q <= core_nrst_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    prog_ram #(
        .AW (ADDR_W),
        .DW (LINE_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (lines_q[ADDR_W-1:0]),
        .wdata (wr_data),
        .raddr (addr),
        .rdata (line)
    );

endmodule
